gumnut_ctrl_seq: RTL

- Parametrised multicycle control sequencer for the Gumnut-style core.
- Consumes pre-decoded instruction-class flags and bus acknowledges; drives datapath strobes and bus cycles.
- Adds multi-channel maskable interrupts with fixed priority, an interrupt-enable register with reti restore, wait/standby handling and an optional bus-ack timeout.
- Sits between the instruction decoder and datapath/bus interfaces.

---
 rtl/gumnut_ctrl_seq_pkg.sv | 40 ++++
 rtl/gumnut_ctrl_seq_if.sv | 23 ++
 rtl/gumnut_irq_prio.sv | 33 +++
 rtl/gumnut_ctrl_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_ctrl_seq_pkg.sv
// Shared encodings for the Gumnut control sequencer.
//   state_e   : 3-bit sequencer state codes, also driven on state_o
//   MEM_*     : mem_op_i encodings
//   MISC_*    : misc_op_i encodings
//   PC_SEL_*  : pc_sel_o encodings
//   REG_SRC_* : reg_src_o encodings
package gumnut_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_INT       = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  localparam logic [1:0] MEM_LDM = 2'b00;
  localparam logic [1:0] MEM_STM = 2'b01;
  localparam logic [1:0] MEM_INP = 2'b10;
  localparam logic [1:0] MEM_OUT = 2'b11;

  localparam logic [2:0] MISC_RET  = 3'd0;
  localparam logic [2:0] MISC_RETI = 3'd1;
  localparam logic [2:0] MISC_ENAI = 3'd2;
  localparam logic [2:0] MISC_DISI = 3'd3;
  localparam logic [2:0] MISC_WAIT = 3'd4;
  localparam logic [2:0] MISC_STBY = 3'd5;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_TGT = 2'b01;
  localparam logic [1:0] PC_SEL_VEC = 2'b10;
  localparam logic [1:0] PC_SEL_RET = 2'b11;

  localparam logic [1:0] REG_SRC_ALU  = 2'b00;
  localparam logic [1:0] REG_SRC_DATA = 2'b01;
  localparam logic [1:0] REG_SRC_PORT = 2'b10;

endpackage

// File: rtl/gumnut_ctrl_seq_if.sv
// Bus handshake bundle between the sequencer and the instruction, data and
// port buses.
//   master : sequencer side (drives cyc/stb/we, receives acks)
//   slave  : bus side (receives cyc/stb/we, drives acks)
interface gumnut_ctrl_seq_if;
  logic inst_cyc_o, inst_stb_o, inst_ack_i;
  logic data_cyc_o, data_stb_o, data_we_o, data_ack_i;
  logic port_cyc_o, port_stb_o, port_we_o, port_ack_i;

  modport master (
    output inst_cyc_o, inst_stb_o,
    output data_cyc_o, data_stb_o, data_we_o,
    output port_cyc_o, port_stb_o, port_we_o,
    input  inst_ack_i, data_ack_i, port_ack_i
  );

  modport slave (
    input  inst_cyc_o, inst_stb_o,
    input  data_cyc_o, data_stb_o, data_we_o,
    input  port_cyc_o, port_stb_o, port_we_o,
    output inst_ack_i, data_ack_i, port_ack_i
  );
endinterface

// File: rtl/gumnut_irq_prio.sv
// Interrupt pending mask and fixed-priority (lowest index wins) encoder.
//   irq_i      : level requests
//   irq_mask_i : 1 = channel enabled
//   pend_any_o : some enabled channel is requesting
//   onehot_o   : one-hot winner (0 when nothing pending)
//   id_o       : winner index (0 when nothing pending)
module gumnut_irq_prio #(
  parameter  int NUM_IRQ = 4,
  localparam int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic               pend_any_o,
  output logic [NUM_IRQ-1:0] onehot_o,
  output logic [IRQ_W-1:0]   id_o
);

  logic [NUM_IRQ-1:0] pend;

  assign pend       = irq_i & irq_mask_i;
  assign pend_any_o = |pend;
  // Isolate the lowest set bit.
  assign onehot_o   = pend & (~pend + NUM_IRQ'(1));

  // Scan high to low so the lowest pending index is the last to assign.
  always_comb begin
    id_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) id_o = IRQ_W'(i);
    end
  end

endmodule

// File: rtl/gumnut_ctrl_seq.sv
// Multicycle control sequencer for the Gumnut-style core.
// Takes pre-decoded instruction class flags and bus acks, drives datapath
// strobes and bus cycles, and services maskable fixed-priority interrupts.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   bus               : inst/data/port cyc/stb/we and acks (master side)
//   is_*_i, *_op_i    : instruction class and sub-op, valid in DECODE
//   branch_taken_i    : branch condition, valid in DECODE
//   irq_i, irq_mask_i : interrupt requests and enables
//   ir_ld_o .. alu_en_o : datapath strobes
//   int_save_o, int_ack_o, irq_id_o, int_en_o : interrupt entry / status
//   stby_o, bus_err_o, state_o : status and debug
// Optional: define CTRL_BUS_TIMEOUT_EN to abort to ERR when a bus strobe
// waits ACK_TIMEOUT-1 cycles without acknowledge.
module gumnut_ctrl_seq
  import gumnut_ctrl_pkg::*;
#(
  parameter  int NUM_IRQ     = 4,
  parameter  int ACK_TIMEOUT = 16,
  localparam int IRQ_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gumnut_ctrl_seq_if.master  bus,
  input  logic               is_alu_i,
  input  logic               is_mem_i,
  input  logic               is_branch_i,
  input  logic               is_jump_i,
  input  logic               is_misc_i,
  input  logic [1:0]         mem_op_i,
  input  logic [2:0]         misc_op_i,
  input  logic               branch_taken_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  output logic               ir_ld_o,
  output logic               pc_ld_o,
  output logic [1:0]         pc_sel_o,
  output logic               reg_we_o,
  output logic [1:0]         reg_src_o,
  output logic               alu_en_o,
  output logic               int_save_o,
  output logic [NUM_IRQ-1:0] int_ack_o,
  output logic [IRQ_W-1:0]   irq_id_o,
  output logic               int_en_o,
  output logic               stby_o,
  output logic               bus_err_o,
  output logic [2:0]         state_o
);

  state_e     state_q, state_d;
  logic       int_en_q, int_en_d;
  // Class info captured in DECODE so later states don't rely on the decoder.
  logic       is_mem_q;
  logic [1:0] mem_op_q;

  logic               pend_any;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [IRQ_W-1:0]   win_id;
  logic               take_int;
  logic               ack_sel;

  gumnut_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .irq_i      (irq_i),
    .irq_mask_i (irq_mask_i),
    .pend_any_o (pend_any),
    .onehot_o   (win_onehot),
    .id_o       (win_id)
  );

  assign take_int = int_en_q & pend_any;

  // Ack relevant to the current state; acks elsewhere are ignored.
  always_comb begin
    ack_sel = 1'b0;
    if (state_q == ST_FETCH)    ack_sel = bus.inst_ack_i;
    else if (state_q == ST_MEM) ack_sel = mem_op_q[1] ? bus.port_ack_i : bus.data_ack_i;
  end

`ifdef CTRL_BUS_TIMEOUT_EN
  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  logic             tmo;

  // Fires on the cycle the count would reach ACK_TIMEOUT-1.
  assign tmo = (state_q == ST_FETCH || state_q == ST_MEM) && !ack_sel &&
               (cnt_q == CNT_W'(ACK_TIMEOUT - 2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if ((state_q == ST_FETCH || state_q == ST_MEM) && !ack_sel && state_d == state_q)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
      if (tmo) bus_err_q <= 1'b1;
    end
  end

  assign bus_err_o = bus_err_q & ~rst_i;
`else
  assign bus_err_o = 1'b0;
`endif

  logic inst_cyc, inst_stb, data_cyc, data_stb, data_we, port_cyc, port_stb, port_we;

  always_comb begin
    state_d    = state_q;
    int_en_d   = int_en_q;
    inst_cyc   = 1'b0;
    inst_stb   = 1'b0;
    data_cyc   = 1'b0;
    data_stb   = 1'b0;
    data_we    = 1'b0;
    port_cyc   = 1'b0;
    port_stb   = 1'b0;
    port_we    = 1'b0;
    ir_ld_o    = 1'b0;
    pc_ld_o    = 1'b0;
    pc_sel_o   = PC_SEL_INC;
    reg_we_o   = 1'b0;
    reg_src_o  = REG_SRC_ALU;
    alu_en_o   = 1'b0;
    int_save_o = 1'b0;
    int_ack_o  = '0;
    irq_id_o   = '0;
    stby_o     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        inst_cyc = 1'b1;
        inst_stb = 1'b1;
        if (bus.inst_ack_i) begin
          ir_ld_o = 1'b1;
          pc_ld_o = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu_i || is_mem_i) begin
          state_d = ST_EXECUTE;
        end else if (is_branch_i) begin
          pc_ld_o  = branch_taken_i;
          pc_sel_o = PC_SEL_TGT;
          state_d  = take_int ? ST_INT : ST_FETCH;
        end else if (is_jump_i) begin
          pc_ld_o  = 1'b1;
          pc_sel_o = PC_SEL_TGT;
          state_d  = take_int ? ST_INT : ST_FETCH;
        end else if (is_misc_i) begin
          case (misc_op_i)
            MISC_RET: begin
              pc_ld_o  = 1'b1;
              pc_sel_o = PC_SEL_RET;
              state_d  = take_int ? ST_INT : ST_FETCH;
            end
            MISC_RETI: begin
              // Restored enable already counts for this End decision.
              pc_ld_o  = 1'b1;
              pc_sel_o = PC_SEL_RET;
              int_en_d = 1'b1;
              state_d  = pend_any ? ST_INT : ST_FETCH;
            end
            MISC_ENAI: begin
              int_en_d = 1'b1;
              state_d  = take_int ? ST_INT : ST_FETCH;
            end
            MISC_DISI: begin
              int_en_d = 1'b0;
              state_d  = take_int ? ST_INT : ST_FETCH;
            end
            MISC_WAIT, MISC_STBY: begin
              // Parked here until an interrupt is taken; with int_en=0
              // only reset gets us out.
              if (take_int) state_d = ST_INT;
              else          stby_o  = 1'b1;
            end
            default: state_d = take_int ? ST_INT : ST_FETCH;
          endcase
        end else begin
          state_d = take_int ? ST_INT : ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        alu_en_o = 1'b1;
        state_d  = is_mem_q ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        if (!mem_op_q[1]) begin
          data_cyc = 1'b1;
          data_stb = 1'b1;
          data_we  = (mem_op_q == MEM_STM);
        end else begin
          port_cyc = 1'b1;
          port_stb = 1'b1;
          port_we  = (mem_op_q == MEM_OUT);
        end
        if (ack_sel) begin
          if (mem_op_q == MEM_LDM || mem_op_q == MEM_INP) state_d = ST_WRITEBACK;
          else state_d = take_int ? ST_INT : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        reg_we_o = 1'b1;
        if (is_mem_q) reg_src_o = (mem_op_q == MEM_INP) ? REG_SRC_PORT : REG_SRC_DATA;
        state_d = take_int ? ST_INT : ST_FETCH;
      end
      ST_INT: begin
        int_save_o = 1'b1;
        pc_ld_o    = 1'b1;
        pc_sel_o   = PC_SEL_VEC;
        int_ack_o  = win_onehot;
        irq_id_o   = win_id;
        int_en_d   = 1'b0;
        state_d    = ST_FETCH;
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_FETCH;
    endcase

`ifdef CTRL_BUS_TIMEOUT_EN
    if (tmo) state_d = ST_ERR;
`endif

    // Everything quiet while reset is held, even though state reads FETCH.
    if (rst_i) begin
      inst_cyc   = 1'b0;
      inst_stb   = 1'b0;
      ir_ld_o    = 1'b0;
      pc_ld_o    = 1'b0;
      pc_sel_o   = PC_SEL_INC;
      reg_we_o   = 1'b0;
      reg_src_o  = REG_SRC_ALU;
      alu_en_o   = 1'b0;
      int_save_o = 1'b0;
      int_ack_o  = '0;
      irq_id_o   = '0;
      stby_o     = 1'b0;
      data_cyc   = 1'b0;
      data_stb   = 1'b0;
      data_we    = 1'b0;
      port_cyc   = 1'b0;
      port_stb   = 1'b0;
      port_we    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_FETCH;
      int_en_q <= 1'b0;
      is_mem_q <= 1'b0;
      mem_op_q <= MEM_LDM;
    end else begin
      state_q  <= state_d;
      int_en_q <= int_en_d;
      if (state_q == ST_DECODE) begin
        is_mem_q <= is_mem_i;
        mem_op_q <= mem_op_i;
      end
    end
  end

  assign bus.inst_cyc_o = inst_cyc;
  assign bus.inst_stb_o = inst_stb;
  assign bus.data_cyc_o = data_cyc;
  assign bus.data_stb_o = data_stb;
  assign bus.data_we_o  = data_we;
  assign bus.port_cyc_o = port_cyc;
  assign bus.port_stb_o = port_stb;
  assign bus.port_we_o  = port_we;

  assign int_en_o = int_en_q & ~rst_i;
  assign state_o  = rst_i ? 3'd0 : state_q;

endmodule
